// File: rtl/fetch_decode_register_pkg.sv
// Shared encodings for the IF/ID stage: FSM states, packet layout and
// opcode field positions used by fetch/decode.
package fetch_decode_register_pkg;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } fd_state_e;

  localparam logic [15:0] NOP_WORD        = 16'h0000;
  localparam logic [1:0]  TWO_WORD_PREFIX = 2'b11;

  localparam int PREFIX_HI = 15;
  localparam int PREFIX_LO = 14;
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 11;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        valid;
    logic        two_word;
  } fd_pkt_t;

  function automatic logic [PREFIX_HI-PREFIX_LO:0] word_prefix(input logic [15:0] word);
    return word[PREFIX_HI:PREFIX_LO];
  endfunction

  function automatic logic [OPCODE_HI-OPCODE_LO:0] word_opcode(input logic [15:0] word);
    return word[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_decode_register.sv
// IF/ID register: merges opcode + immediate words into one decode packet,
// with stall (hold) and flush (bubble) from hazard/branch control.
module fetch_decode_register
  import fetch_decode_register_pkg::*;
#(
  parameter logic [15:0] NOP_WORD        = fetch_decode_register_pkg::NOP_WORD,
  parameter logic [1:0]  TWO_WORD_PREFIX = fetch_decode_register_pkg::TWO_WORD_PREFIX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction_in,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instruction_out,
  output logic [15:0] immediate_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        two_word_out
);

  fd_state_e   state, state_nxt;
  fd_pkt_t     pkt, pkt_nxt;
  logic [15:0] hold_instr, hold_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FIRST;
      pkt        <= '{instr: NOP_WORD, imm: '0, pc: '0, valid: 1'b0, two_word: 1'b0};
      hold_instr <= '0;
    end else begin
      state      <= state_nxt;
      pkt        <= pkt_nxt;
      hold_instr <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pkt_nxt   = pkt;
    hold_nxt  = hold_instr;
    if (flush) begin
      // pc_out keeps the last real link address; hold_instr is simply
      // orphaned by returning to S_FIRST.
      state_nxt        = S_FIRST;
      pkt_nxt.instr    = NOP_WORD;
      pkt_nxt.imm      = '0;
      pkt_nxt.valid    = 1'b0;
      pkt_nxt.two_word = 1'b0;
    end else if (!stall) begin
      unique case (state)
        S_FIRST: begin
          if (word_prefix(instruction_in) == TWO_WORD_PREFIX) begin
            hold_nxt         = instruction_in;
            pkt_nxt.instr    = NOP_WORD;
            pkt_nxt.valid    = 1'b0;
            pkt_nxt.two_word = 1'b0;
            state_nxt        = S_SECOND;
          end else begin
            pkt_nxt = '{instr: instruction_in, imm: '0, pc: pc_in,
                        valid: 1'b1, two_word: 1'b0};
          end
        end
        S_SECOND: begin
          // Second word is pure data, even if its top bits look like a prefix.
          pkt_nxt   = '{instr: hold_instr, imm: instruction_in, pc: pc_in,
                        valid: 1'b1, two_word: 1'b1};
          state_nxt = S_FIRST;
        end
        default: state_nxt = S_FIRST;
      endcase
    end
  end

  assign instruction_out = pkt.instr;
  assign immediate_out   = pkt.imm;
  assign pc_out          = pkt.pc;
  assign valid_out       = pkt.valid;
  assign two_word_out    = pkt.two_word;

endmodule

// File: tb/tb_fetch_decode_register.sv
// Directed bench: each step pushes its expected packet, which is popped and
// checked field-by-field one clock later.
module tb_fetch_decode_register;
  import fetch_decode_register_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction_in;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic [15:0] instruction_out;
  logic [15:0] immediate_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        two_word_out;

  int checks = 0;
  int errors = 0;
  fd_pkt_t sb_q[$];

  fetch_decode_register dut (
    .clk            (clk),
    .reset          (reset),
    .instruction_in (instruction_in),
    .pc_in          (pc_in),
    .stall          (stall),
    .flush          (flush),
    .instruction_out(instruction_out),
    .immediate_out  (immediate_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .two_word_out   (two_word_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic fl, input logic st,
                      input logic [15:0] ins, input logic [31:0] pc,
                      input logic [15:0] e_ins, input logic [15:0] e_imm,
                      input logic [31:0] e_pc, input logic e_v, input logic e_tw);
    fd_pkt_t e;
    reset = rst; flush = fl; stall = st; instruction_in = ins; pc_in = pc;
    sb_q.push_back('{instr: e_ins, imm: e_imm, pc: e_pc, valid: e_v, two_word: e_tw});
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, {16'h0, instruction_out}, {16'h0, e.instr});
      chk({tag, "_imm"},   {16'h0, immediate_out},   {16'h0, e.imm});
      chk({tag, "_pc"},    pc_out,                   e.pc);
      chk({tag, "_valid"}, {31'h0, valid_out},       {31'h0, e.valid});
      chk({tag, "_tw"},    {31'h0, two_word_out},    {31'h0, e.two_word});
    end
  endtask

  initial begin
    //          tag        rst fl st  instr     pc            exp: instr    imm       pc            v tw
    step("rst0",      1, 0, 0, 16'h1234, 32'd34,       16'h0000, 16'h0000, 32'd0,        0, 0);
    step("rst1",      1, 0, 0, 16'h1234, 32'd34,       16'h0000, 16'h0000, 32'd0,        0, 0);
    step("one",       0, 0, 0, 16'h1234, 32'd34,       16'h1234, 16'h0000, 32'd34,       1, 0);
    step("two_a",     0, 0, 0, 16'hC801, 32'd36,       16'h0000, 16'h0000, 32'd34,       0, 0);
    step("two_b",     0, 0, 0, 16'h00FF, 32'd38,       16'hC801, 16'h00FF, 32'd38,       1, 1);
    // stall while waiting for the immediate
    step("st_a",      0, 0, 0, 16'hC801, 32'd40,       16'h0000, 16'h00FF, 32'd38,       0, 0);
    step("st_h1",     0, 0, 1, 16'h5555, 32'd42,       16'h0000, 16'h00FF, 32'd38,       0, 0);
    step("st_h2",     0, 0, 1, 16'hC000, 32'd44,       16'h0000, 16'h00FF, 32'd38,       0, 0);
    step("st_h3",     0, 0, 1, 16'h1234, 32'd46,       16'h0000, 16'h00FF, 32'd38,       0, 0);
    step("st_rel",    0, 0, 0, 16'h0042, 32'd48,       16'hC801, 16'h0042, 32'd48,       1, 1);
    // flush while waiting for the immediate
    step("fl_a",      0, 0, 0, 16'hC801, 32'd50,       16'h0000, 16'h0042, 32'd48,       0, 0);
    step("fl_f",      0, 1, 0, 16'h2222, 32'd52,       16'h0000, 16'h0000, 32'd48,       0, 0);
    step("fl_next",   0, 0, 0, 16'h1111, 32'd54,       16'h1111, 16'h0000, 32'd54,       1, 0);
    // flush beats stall
    step("fs_a",      0, 0, 0, 16'hC801, 32'd56,       16'h0000, 16'h0000, 32'd54,       0, 0);
    step("fs_fs",     0, 1, 1, 16'h3333, 32'd58,       16'h0000, 16'h0000, 32'd54,       0, 0);
    step("fs_next",   0, 0, 0, 16'h2222, 32'd60,       16'h2222, 16'h0000, 32'd60,       1, 0);
    // reset beats flush and clears pc
    step("rf_pre",    0, 0, 0, 16'h7777, 32'd62,       16'h7777, 16'h0000, 32'd62,       1, 0);
    step("rf",        1, 1, 0, 16'h7777, 32'd64,       16'h0000, 16'h0000, 32'd0,        0, 0);
    // immediate with prefix bits 11 is still data
    step("pfx_a",     0, 0, 0, 16'hC801, 32'd64,       16'h0000, 16'h0000, 32'd0,        0, 0);
    step("pfx_b",     0, 0, 0, 16'hFFFF, 32'd66,       16'hC801, 16'hFFFF, 32'd66,       1, 1);
    // flush after a valid packet keeps pc_out
    step("fl_pc",     0, 1, 0, 16'h0001, 32'd68,       16'h0000, 16'h0000, 32'd66,       0, 0);
    // prefix 10 is one-word; full-width pc passes unchanged
    step("pfx10",     0, 0, 0, 16'hBFFF, 32'hFFFFFFFE, 16'hBFFF, 16'h0000, 32'hFFFFFFFE, 1, 0);
    step("stall_v",   0, 0, 1, 16'h0123, 32'd70,       16'hBFFF, 16'h0000, 32'hFFFFFFFE, 1, 0);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
